// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared widths, header field helpers and address constants for the router datapath
package router_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_BITS  = 2;
  localparam int LEN_BITS   = DATA_WIDTH - ADDR_BITS;

  // Destination 3 does not exist on a 1x3 router.
  localparam logic [ADDR_BITS-1:0] ADDR_INVALID = 2'b11;

  // Payload length field of a header byte.
  function automatic logic [LEN_BITS-1:0] hdr_len(input logic [DATA_WIDTH-1:0] hdr);
    return hdr[DATA_WIDTH-1:ADDR_BITS];
  endfunction

  // Destination address field of a header byte.
  function automatic logic [ADDR_BITS-1:0] hdr_addr(input logic [DATA_WIDTH-1:0] hdr);
    return hdr[ADDR_BITS-1:0];
  endfunction

endpackage

// File: rtl/router_reg.sv
// rtl/router_reg.sv - router datapath registers: header latch, stall hold, dout, running parity and error flag; option ROUTER_REG_ADDR_CHECK_EN
module router_reg
  import router_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic                  fifo_full,
  input  logic                  rst_int_reg,
  input  logic                  detect_add,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] int_par_q, int_par_d;
  logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;
  logic                  parity_done_q, parity_done_d;
  logic                  err_q, err_d;

  // Header latch, stall holding register and received parity byte capture.
  always_comb begin
    hdr_d     = hdr_q;
    hold_d    = hold_q;
    pkt_par_d = pkt_par_q;

    if (detect_add && pkt_valid) begin
`ifdef ROUTER_REG_ADDR_CHECK_EN
      if (hdr_addr(data_in) != ADDR_INVALID) begin
        hdr_d = data_in;
      end
`else
      hdr_d = data_in;
`endif
    end

    if (ld_state && fifo_full) begin
      hold_d = data_in;
    end

    // With pkt_valid low inside LOAD_DATA the byte on data_in is the parity byte.
    if (ld_state && !pkt_valid) begin
      pkt_par_d = data_in;
    end
  end

  // Output byte select: header first, then live payload, then the byte stalled by a full FIFO.
  always_comb begin
    dout_d = dout_q;
    if (lfd_state) begin
      dout_d = hdr_q;
    end else if (ld_state && !fifo_full) begin
      dout_d = data_in;
    end else if (laf_state) begin
      dout_d = hold_q;
    end
  end

  // Running XOR over header and payload; the FIFO_FULL state must not fold a byte in twice.
  always_comb begin
    int_par_d = int_par_q;
    if (detect_add) begin
      int_par_d = '0;
    end else if (lfd_state) begin
      int_par_d = int_par_q ^ hdr_q;
    end else if (ld_state && pkt_valid && !full_state) begin
      int_par_d = int_par_q ^ data_in;
    end
  end

  // End-of-packet flags and the parity comparison that follows parity_done by one clock.
  always_comb begin
    low_pkt_valid_d = low_pkt_valid_q;
    parity_done_d   = parity_done_q;
    err_d           = err_q;

    if (rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end

    // Parity is done either when the parity byte goes straight out, or when it was
    // stalled and finally leaves through LOAD_AFTER_FULL.
    if (detect_add) begin
      parity_done_d = 1'b0;
    end else if (ld_state && !fifo_full && !pkt_valid) begin
      parity_done_d = 1'b1;
    end else if (laf_state && low_pkt_valid_q && !parity_done_q) begin
      parity_done_d = 1'b1;
    end

    if (detect_add) begin
      err_d = 1'b0;
    end else if (parity_done_q) begin
      err_d = (int_par_q != pkt_par_q);
    end
  end

  // State register; a reset mid-packet discards everything.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      hdr_q           <= '0;
      hold_q          <= '0;
      int_par_q       <= '0;
      pkt_par_q       <= '0;
      dout_q          <= '0;
      low_pkt_valid_q <= 1'b0;
      parity_done_q   <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      hdr_q           <= hdr_d;
      hold_q          <= hold_d;
      int_par_q       <= int_par_d;
      pkt_par_q       <= pkt_par_d;
      dout_q          <= dout_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      parity_done_q   <= parity_done_d;
      err_q           <= err_d;
    end
  end

  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
// tb/tb_router_reg.sv - self-checking bench for router_reg: vector table, directed corner sequences, random packets
module tb_router_reg;
  import router_pkg::*;

  logic                  clock = 1'b0;
  logic                  resetn, pkt_valid, fifo_full, rst_int_reg;
  logic                  detect_add, ld_state, laf_state, full_state, lfd_state;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  parity_done, low_pkt_valid, err;
  logic [DATA_WIDTH-1:0] dout;

  int total = 0;
  int bad   = 0;

  router_reg dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .fifo_full     (fifo_full),
    .rst_int_reg   (rst_int_reg),
    .detect_add    (detect_add),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .lfd_state     (lfd_state),
    .data_in       (data_in),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err),
    .dout          (dout)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       rn, pv, ff, rst, det, ld, laf, fst, lfd;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic       e_pd, e_lpv, e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic rn, logic pv, logic ff, logic rst, logic det,
                              logic ld, logic laf, logic fst, logic lfd, logic [7:0] din,
                              logic [7:0] e_dout, logic e_pd, logic e_lpv, logic e_err);
    vec_t v;
    v.name = n; v.rn = rn; v.pv = pv; v.ff = ff; v.rst = rst; v.det = det;
    v.ld = ld; v.laf = laf; v.fst = fst; v.lfd = lfd; v.din = din;
    v.e_dout = e_dout; v.e_pd = e_pd; v.e_lpv = e_lpv; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic pv, input logic ff, input logic rst,
                       input logic det, input logic ld, input logic laf, input logic fst,
                       input logic lfd, input logic [7:0] din);
    resetn = rn; pkt_valid = pv; fifo_full = ff; rst_int_reg = rst; detect_add = det;
    ld_state = ld; laf_state = laf; full_state = fst; lfd_state = lfd; data_in = din;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Drives one packet the way the router FSM would, stalling at random, and checks
  // the emitted byte stream and the final error flag against a plain XOR of the bytes.
  task automatic send_pkt(input int len, input logic [1:0] addr, input bit corrupt);
    logic [7:0] bytes[$];
    logic [7:0] hdr, par, prev, b;
    logic [5:0] len6;
    bit         pv;
    len6 = len[5:0];
    hdr  = {len6, addr};
    par  = hdr;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      bytes.push_back(b);
      par ^= b;
    end
    bytes.push_back(corrupt ? (par ^ (8'h01 << $urandom_range(0, 7))) : par);

    drive(1, 1, 0, 0, 1, 0, 0, 0, 0, hdr); tick;
    check("rnd det parity_done", {7'd0, parity_done}, 8'd0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1, bytes[0]); tick;
    check("rnd lfd dout", dout, hdr);
    prev = hdr;
    for (int k = 0; k <= len; k++) begin
      b  = bytes[k];
      pv = (k < len);
      if ($urandom_range(0, 3) == 0) begin
        drive(1, pv, 1, 0, 0, 1, 0, 0, 0, b); tick;
        check("rnd stall dout", dout, prev);
        repeat ($urandom_range(0, 2)) begin
          drive(1, pv, 1, 0, 0, 0, 0, 1, 0, b); tick;
          check("rnd full dout", dout, prev);
        end
        drive(1, pv, 0, 0, 0, 0, 1, 0, 0, b); tick;
        check("rnd laf dout", dout, b);
      end else begin
        drive(1, pv, 0, 0, 0, 1, 0, 0, 0, b); tick;
        check("rnd ld dout", dout, b);
      end
      prev = b;
    end
    check("rnd parity_done", {7'd0, parity_done}, 8'd1);
    check("rnd low_pkt_valid", {7'd0, low_pkt_valid}, 8'd1);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00); tick;
    check("rnd low_pkt_valid cleared", {7'd0, low_pkt_valid}, 8'd0);
    check("rnd err", {7'd0, err}, {7'd0, corrupt});
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);

    //           name        rn pv ff rs de ld lf fs lfd din    dout  pd lpv err
    tbl.push_back(mk("reset",     0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl.push_back(mk("g hdr",     1, 1, 0, 0, 1, 0, 0, 0, 0, 8'h16, 8'h00, 0, 0, 0));
    tbl.push_back(mk("g lfd",     1, 1, 0, 0, 0, 0, 0, 0, 1, 8'h11, 8'h16, 0, 0, 0));
    tbl.push_back(mk("g p11",     1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h11, 8'h11, 0, 0, 0));
    tbl.push_back(mk("g p22",     1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h22, 8'h22, 0, 0, 0));
    tbl.push_back(mk("g p33",     1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h33, 8'h33, 0, 0, 0));
    tbl.push_back(mk("g p44",     1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h44, 8'h44, 0, 0, 0));
    tbl.push_back(mk("g p55",     1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h55, 8'h55, 0, 0, 0));
    tbl.push_back(mk("g par07",   1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h07, 8'h07, 1, 1, 0));
    tbl.push_back(mk("g chk",     1, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h07, 1, 0, 0));
    tbl.push_back(mk("b hdr",     1, 1, 0, 0, 1, 0, 0, 0, 0, 8'h16, 8'h07, 0, 0, 0));
    tbl.push_back(mk("b lfd",     1, 1, 0, 0, 0, 0, 0, 0, 1, 8'h11, 8'h16, 0, 0, 0));
    tbl.push_back(mk("b p11",     1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h11, 8'h11, 0, 0, 0));
    tbl.push_back(mk("b p22",     1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h22, 8'h22, 0, 0, 0));
    tbl.push_back(mk("b p33",     1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h33, 8'h33, 0, 0, 0));
    tbl.push_back(mk("b p44",     1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h44, 8'h44, 0, 0, 0));
    tbl.push_back(mk("b p55",     1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h55, 8'h55, 0, 0, 0));
    tbl.push_back(mk("b par08",   1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h08, 8'h08, 1, 1, 0));
    tbl.push_back(mk("b err",     1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h08, 1, 1, 1));
    tbl.push_back(mk("b rst_int", 1, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h08, 1, 0, 1));
    tbl.push_back(mk("b nexthdr", 1, 1, 0, 0, 1, 0, 0, 0, 0, 8'h16, 8'h08, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rn, tbl[i].pv, tbl[i].ff, tbl[i].rst, tbl[i].det, tbl[i].ld,
            tbl[i].laf, tbl[i].fst, tbl[i].lfd, tbl[i].din);
      tick;
      check({tbl[i].name, " dout"}, dout, tbl[i].e_dout);
      check({tbl[i].name, " parity_done"}, {7'd0, parity_done}, {7'd0, tbl[i].e_pd});
      check({tbl[i].name, " low_pkt_valid"}, {7'd0, low_pkt_valid}, {7'd0, tbl[i].e_lpv});
      check({tbl[i].name, " err"}, {7'd0, err}, {7'd0, tbl[i].e_err});
    end

    // FIFO full on payload 0x33: dout holds, stalled byte replays via LOAD_AFTER_FULL,
    // and no parity is accumulated while full_state is up (even if ld_state is also high).
    drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 8'h16); tick;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 8'h11); tick; check("ff lfd dout", dout, 8'h16);
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h11); tick; check("ff p11 dout", dout, 8'h11);
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h22); tick; check("ff p22 dout", dout, 8'h22);
    drive(1, 1, 1, 0, 0, 1, 0, 0, 0, 8'h33); tick; check("ff stall dout", dout, 8'h22);
    drive(1, 1, 1, 0, 0, 1, 0, 1, 0, 8'h33); tick; check("ff full+ld dout", dout, 8'h22);
    drive(1, 1, 1, 0, 0, 0, 0, 1, 0, 8'h33); tick; check("ff full dout", dout, 8'h22);
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00); tick; check("ff laf dout", dout, 8'h33);
    check("ff laf parity_done", {7'd0, parity_done}, 8'd0);
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h44); tick; check("ff p44 dout", dout, 8'h44);
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h55); tick; check("ff p55 dout", dout, 8'h55);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h07); tick; check("ff par pd", {7'd0, parity_done}, 8'd1);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00); tick; check("ff err", {7'd0, err}, 8'd0);

    // Parity byte arrives while full: parity_done comes from LOAD_AFTER_FULL instead.
    drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 8'h04); tick;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 8'h5A); tick; check("pf lfd dout", dout, 8'h04);
    drive(1, 1, 0, 0, 0, 1, 0, 0, 0, 8'h5A); tick; check("pf p dout", dout, 8'h5A);
    drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 8'h5E); tick;
    check("pf stall lpv", {7'd0, low_pkt_valid}, 8'd1);
    check("pf stall pd", {7'd0, parity_done}, 8'd0);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00); tick;
    check("pf laf dout", dout, 8'h5E);
    check("pf laf pd", {7'd0, parity_done}, 8'd1);
    drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00); tick; check("pf err", {7'd0, err}, 8'd0);

    // Header with address 3: gated out when the address check is built in.
    drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 8'h16); tick;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 8'h00); tick; check("addr ok lfd", dout, 8'h16);
    drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 8'h17); tick;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 8'h00); tick;
`ifdef ROUTER_REG_ADDR_CHECK_EN
    check("addr3 hdr kept", dout, 8'h16);
`else
    check("addr3 hdr loaded", dout, 8'h17);
`endif

    // Reset in the middle of a packet clears everything.
    drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 8'h0A); tick;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1, 8'h00); tick;
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 8'h99); tick;
    check("mid pd before reset", {7'd0, parity_done}, 8'd1);
    drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 8'h77); tick;
    check("mid rst dout", dout, 8'h00);
    check("mid rst pd", {7'd0, parity_done}, 8'd0);
    check("mid rst lpv", {7'd0, low_pkt_valid}, 8'd0);
    check("mid rst err", {7'd0, err}, 8'd0);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 8'h00); tick;
    check("mid rst hold cleared", dout, 8'h00);

    for (int p = 0; p < 30; p++) begin
      send_pkt($urandom_range(1, 12), 2'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
